add32_seq_arbiter: RTL and testbench

//  Controller that shares one external 16-bit CLA adder (adder_16bits) between two requesters.

---
 rtl/add32_seq_arbiter_if.sv | 55 +++++
 rtl/add32_seq_arbiter.sv | 140 ++++++++++++++
 tb/tb_add32_seq_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/add32_seq_arbiter_if.sv
// Bus bundle for add32_seq_arbiter: two request channels, the shared
// half-width adder port and the response channel.
// slave  = arbiter side, master = requester/adder/consumer side.
interface add32_seq_arbiter_if #(
    parameter int unsigned HALF_W = 16
);
    localparam int unsigned W = 2 * HALF_W;

    logic              req0_valid;
    logic              req0_ready;
    logic [W-1:0]      req0_a;
    logic [W-1:0]      req0_b;
    logic              req0_sub;

    logic              req1_valid;
    logic              req1_ready;
    logic [W-1:0]      req1_a;
    logic [W-1:0]      req1_b;
    logic              req1_sub;

    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_cin;
    logic [HALF_W-1:0] add_sum;
    logic              add_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_cout;
    logic              rsp_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf,
        output rsp_ready
    );
endinterface

// File: rtl/add32_seq_arbiter.sv
// add32_seq_arbiter: shares one external HALF_W-bit adder between two
// requesters. Each accepted 2*HALF_W-bit add/sub runs as a low pass then a
// high pass with the carry held in a register between them.
// Optional build macro: ADD32_SAT_EN -- saturate the result on signed overflow.
module add32_seq_arbiter #(
    parameter int unsigned HALF_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    add32_seq_arbiter_if.slave   bus
);
    localparam int unsigned W = 2 * HALF_W;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            state_q;
    logic [HALF_W-1:0] a_hi_q;
    logic [HALF_W-1:0] beff_hi_q;
    logic [HALF_W-1:0] res_lo_q;
    logic              id_q;
    logic              last_grant_q;
    logic [W-1:0]      result_q;
    logic              cout_q;
    logic              ovf_q;
    logic              valid_q;
    logic [HALF_W-1:0] add_a_q;
    logic [HALF_W-1:0] add_b_q;
    logic              add_cin_q;  // also holds the inter-pass carry during HI

    logic              grant_any;
    logic              grant_id;
    logic              accept;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_beff;
    logic              sel_sub;
    logic              ovf_now;
    logic [W-1:0]      result_next;

    // Round-robin grant and combinational ready, only in IDLE.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
        accept         = (state_q == StIdle) && grant_any;
        bus.req0_ready = accept && !grant_id;
        bus.req1_ready = accept && grant_id;
    end

    // Operand select for the granted requester; subtraction inverts B here.
    always_comb begin
        sel_a    = grant_id ? bus.req1_a : bus.req0_a;
        sel_sub  = grant_id ? bus.req1_sub : bus.req0_sub;
        sel_beff = grant_id ? bus.req1_b : bus.req0_b;
        if (sel_sub) begin
            sel_beff = ~sel_beff;
        end
    end

    // High-pass overflow detect and final result (optionally saturated).
    always_comb begin
        ovf_now     = (a_hi_q[HALF_W-1] == beff_hi_q[HALF_W-1]) &&
                      (bus.add_sum[HALF_W-1] != a_hi_q[HALF_W-1]);
        result_next = {bus.add_sum, res_lo_q};
`ifdef ADD32_SAT_EN
        if (ovf_now) begin
            result_next = a_hi_q[HALF_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Sequencer: IDLE -> LO -> HI -> DONE, with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_hi_q       <= '0;
            beff_hi_q    <= '0;
            res_lo_q     <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_hi_q    <= sel_a[W-1:HALF_W];
                        beff_hi_q <= sel_beff[W-1:HALF_W];
                        id_q      <= grant_id;
                        add_a_q   <= sel_a[HALF_W-1:0];
                        add_b_q   <= sel_beff[HALF_W-1:0];
                        add_cin_q <= sel_sub;  // +1 completes two's complement
                        state_q   <= StLo;
                    end
                end
                StLo: begin
                    res_lo_q  <= bus.add_sum;
                    add_a_q   <= a_hi_q;
                    add_b_q   <= beff_hi_q;
                    add_cin_q <= bus.add_cout;
                    state_q   <= StHi;
                end
                StHi: begin
                    result_q  <= result_next;
                    cout_q    <= bus.add_cout;
                    ovf_q     <= ovf_now;
                    valid_q   <= 1'b1;
                    add_a_q   <= '0;
                    add_b_q   <= '0;
                    add_cin_q <= 1'b0;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (bus.rsp_ready) begin
                        valid_q      <= 1'b0;
                        last_grant_q <= id_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_cin    = add_cin_q;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_ovf    = ovf_q;
endmodule

// File: tb/tb_add32_seq_arbiter.sv
// Directed testbench for add32_seq_arbiter with a behavioural 16-bit adder.
module tb_add32_seq_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

`ifdef ADD32_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    add32_seq_arbiter_if #(.HALF_W(16)) bus ();

    add32_seq_arbiter #(.HALF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared adder model: combinational 16-bit add with carry.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // One transaction from a single requester, rsp_ready held high.
    task automatic do_op(input string tag, input bit id, input logic [31:0] a,
                         input logic [31:0] b, input bit sub, input logic [31:0] er,
                         input bit ec, input bit eo);
        logic [31:0] beff;
        beff = sub ? ~b : b;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
        end
        #1;
        chk({tag, "_ready"}, 32'({bus.req1_ready, bus.req0_ready}), id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        drop_valids();
        @(negedge clk);
        chk({tag, "_lo_ports"}, {bus.add_a, bus.add_b}, {a[15:0], beff[15:0]});
        chk({tag, "_lo_cin"}, 32'(bus.add_cin), 32'(sub));
        chk({tag, "_vld1"}, 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_hi_ports"}, {bus.add_a, bus.add_b}, {a[31:16], beff[31:16]});
        chk({tag, "_vld2"}, 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_vld3"}, 32'(bus.rsp_valid), 1);
        chk({tag, "_result"}, bus.rsp_result, er);
        chk({tag, "_flags"}, 32'({bus.rsp_id, bus.rsp_cout, bus.rsp_ovf}), 32'({id, ec, eo}));
        chk({tag, "_idle_ports"}, 32'({bus.add_a, bus.add_b, bus.add_cin}), 0);
        @(posedge clk);
        #1;
        chk({tag, "_rsp_done"}, 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        logic got;
        logic exp_id;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;

        // Reset state
        #12;
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_ovf}), 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_adder", 32'({bus.add_a, bus.add_b, bus.add_cin}), 0);
        chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry crossing halves, subtraction with borrow, overflow cases
        do_op("t1_carry", 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
        do_op("t2_sub", 1'b1, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("t3_ovf", 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0,
              SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1);
        do_op("t3b_nobrw", 1'b1, 32'd10, 32'd3, 1'b1, 32'd7, 1'b1, 1'b0);
        do_op("t3c_negovf", 1'b0, 32'h80000000, 32'h00000001, 1'b1,
              SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1);

        // Back-pressure: DONE held for 10 cycles
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 32'h12345678; bus.req0_b = 32'h11111111;
        bus.req0_sub = 1'b0;
        @(posedge clk);
        #1;
        drop_valids();
        repeat (3) @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_result", bus.rsp_result, 32'h23456789);
            chk("bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
            chk("bp_adder", 32'({bus.add_a, bus.add_b, bus.add_cin}), 0);
            @(negedge clk);
        end
        drop_valids();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'(bus.rsp_valid), 0);

        // Reset during the high pass
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_a = 32'h00030001; bus.req1_b = 32'h00050002;
        bus.req1_sub = 1'b0;
        @(posedge clk);
        #1;
        drop_valids();
        repeat (2) @(negedge clk);
        chk("mid_hi_a", 32'(bus.add_a), 32'h0003);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_adder", 32'({bus.add_a, bus.add_b, bus.add_cin}), 0);
        chk("mid_rst_rsp", 32'({bus.rsp_valid, bus.rsp_cout, bus.rsp_ovf}), 0);
        chk("mid_rst_result", bus.rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(bus.rsp_valid), 0);
        end
        do_op("t6_after", 1'b1, 32'h00030001, 32'h00050002, 1'b0, 32'h00080003, 1'b0, 1'b0);

        // Round-robin with both requesters always valid
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_a = 32'd1;  bus.req0_b = 32'd1;  bus.req0_sub = 1'b0;
        bus.req1_a = 32'h10; bus.req1_b = 32'h20; bus.req1_sub = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        exp_id = 1'b0;
        for (int op = 0; op < 4; op++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) got = 1'b1;
                else @(negedge clk);
            end
            chk("rr_seen", 32'(got), 1);
            chk("rr_grant", 32'({bus.req1_ready, bus.req0_ready}), exp_id ? 32'd2 : 32'd1);
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (bus.rsp_valid) got = 1'b1;
                else chk("rr_busy_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
            end
            chk("rr_rsp_seen", 32'(got), 1);
            chk("rr_id", 32'(bus.rsp_id), 32'(exp_id));
            chk("rr_result", bus.rsp_result, exp_id ? 32'h30 : 32'd2);
            @(negedge clk);
            exp_id = ~exp_id;
        end
        drop_valids();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
